// File: rtl/zap_wb_mem_responder_if.sv
// Wishbone B3 classic single-transfer bus bundle between an initiator and
// zap_wb_mem_responder.
interface zap_wb_mem_responder_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_wen;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat,
    output o_wb_dat, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/zap_wb_mem_responder.sv
// Wishbone classic responder over a word-addressed RAM with WAIT_STATES latency.
// Define ZAP_WB_RESPONDER_ERR_EN to answer out-of-range accesses with o_wb_err.
module zap_wb_mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                   i_clk,
  input logic                   i_reset,
  zap_wb_mem_responder_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp;
  logic        accept;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        wen_q;
  logic        err_q;
  logic [31:0] rdata;
  logic [31:0] mem [DEPTH];

  // With zero wait states the response is built on the accepting edge itself,
  // so the live bus values stand in for the not-yet-latched copies.
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        req_wen;
  logic [31:0] offset;
  logic [AW-1:0] index;
  logic        req_err;
  logic        do_write;

  assign accept  = (state == IDLE) && wb.i_wb_cyc && wb.i_wb_stb;
  assign req_adr = (state == IDLE) ? wb.i_wb_adr : adr_q;
  assign req_dat = (state == IDLE) ? wb.i_wb_dat : dat_q;
  assign req_sel = (state == IDLE) ? wb.i_wb_sel : sel_q;
  assign req_wen = (state == IDLE) ? wb.i_wb_wen : wen_q;
  assign offset  = req_adr - BASE_ADDR;
  assign index   = offset[AW+1:2];

  logic unused_offset;
`ifdef ZAP_WB_RESPONDER_ERR_EN
  assign req_err       = ({1'b0, offset} >= SPAN);
  assign unused_offset = ^offset[1:0];
`else
  assign req_err       = 1'b0;
  assign unused_offset = ^{offset[31:AW+2], offset[1:0], SPAN};
`endif

  assign do_write = enter_resp && req_wen && !req_err;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb.i_wb_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nxt  = RESP;
          cnt_nxt    = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      err_q <= 1'b0;
      rdata <= 32'd0;
      adr_q <= 32'd0;
      dat_q <= 32'd0;
      sel_q <= 4'd0;
      wen_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        adr_q <= wb.i_wb_adr;
        dat_q <= wb.i_wb_dat;
        sel_q <= wb.i_wb_sel;
        wen_q <= wb.i_wb_wen;
      end
      if (enter_resp) begin
        err_q <= req_err;
        rdata <= (req_wen || req_err) ? 32'd0 : mem[index];
      end
    end
  end

  // RAM is deliberately left out of reset so contents survive i_reset.
  always_ff @(posedge i_clk) begin
    if (do_write && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel[b]) mem[index][8*b +: 8] <= req_dat[8*b +: 8];
      end
    end
  end

  assign wb.o_wb_ack = (state == RESP) && !err_q;
  assign wb.o_wb_err = (state == RESP) && err_q;
  assign wb.o_wb_dat = rdata;
endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// Directed bench: two responders (0 and 3 wait states) checked every cycle
// against a transaction-level model, plus literal expectations.
module tb_zap_wb_mem_responder;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] dat;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst = 2'b11;
  logic [1:0]  cyc = '0, stb = '0, wen = '0;
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [1:0]  ack, err;
  logic [31:0] rdat [2];

  zap_wb_mem_responder_if w0 ();
  zap_wb_mem_responder_if w3 ();

  assign w0.i_wb_cyc = cyc[0];
  assign w0.i_wb_stb = stb[0];
  assign w0.i_wb_wen = wen[0];
  assign w0.i_wb_sel = sel[0];
  assign w0.i_wb_adr = adr[0];
  assign w0.i_wb_dat = wd[0];
  assign w3.i_wb_cyc = cyc[1];
  assign w3.i_wb_stb = stb[1];
  assign w3.i_wb_wen = wen[1];
  assign w3.i_wb_sel = sel[1];
  assign w3.i_wb_adr = adr[1];
  assign w3.i_wb_dat = wd[1];
  assign ack[0] = w0.o_wb_ack;
  assign err[0] = w0.o_wb_err;
  assign rdat[0] = w0.o_wb_dat;
  assign ack[1] = w3.o_wb_ack;
  assign err[1] = w3.o_wb_err;
  assign rdat[1] = w3.o_wb_dat;

  zap_wb_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut0 (
    .i_clk(clk), .i_reset(rst[0]), .wb(w0));
  zap_wb_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(BASE)) dut3 (
    .i_clk(clk), .i_reset(rst[1]), .wb(w3));

  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  bit          chk_en = 1'b0;
  logic [31:0] mm [2][DEPTH];
  logic [31:0] last_dat [2];
  rsp_t        q0 [$];
  rsp_t        q1 [$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic push(input int d, input rsp_t r);
    if (d == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Per-cycle comparison of both responders against the model's response queue.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        bit   e_ack, e_err;
        rsp_t r;
        e_ack = 1'b0;
        e_err = 1'b0;
        if (d == 0 && q0.size() > 0 && q0[0].cyc == cyc_n) begin
          r = q0.pop_front(); e_ack = !r.err; e_err = r.err; last_dat[0] = r.dat;
        end else if (d == 1 && q1.size() > 0 && q1[0].cyc == cyc_n) begin
          r = q1.pop_front(); e_ack = !r.err; e_err = r.err; last_dat[1] = r.dat;
        end
        chk($sformatf("ack%0d", d), {31'd0, ack[d]}, {31'd0, e_ack});
        chk($sformatf("err%0d", d), {31'd0, err[d]}, {31'd0, e_err});
        chk($sformatf("dat%0d", d), rdat[d], last_dat[d]);
      end
    end
  end

  // mode 0: normal transfer held until ack; 1: cyc dropped in 2nd wait cycle;
  // 2: reset pulsed in 2nd wait cycle.
  task automatic xfer(input int d, input bit we, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] w, input int mode,
                      output logic [31:0] od, output bit oe, output int lat);
    int          ws;
    int          n;
    int          idx;
    logic [31:0] off;
    bit          inr;
    rsp_t        r;
    ws  = (d == 0) ? 0 : 3;
    off = a - BASE;
    inr = (off < DEPTH * 4);
    idx = int'((off / 4) % DEPTH);
`ifdef ZAP_WB_RESPONDER_ERR_EN
    r.err = !inr;
`else
    r.err = 1'b0;
`endif
    od = '0; oe = 1'b0; lat = -1;
    @(posedge clk); #2;
    cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = we; sel[d] = s; adr[d] = a; wd[d] = w;
    n = cyc_n + 1;
    if (mode == 0) begin
      r.cyc = n + ws;
      r.dat = (we || r.err) ? 32'd0 : mm[d][idx];
      if (we && !r.err)
        for (int b = 0; b < 4; b++)
          if (s[b]) mm[d][idx][8*b +: 8] = w[8*b +: 8];
      push(d, r);
      for (int k = 0; k < 20 && lat < 0; k++) begin
        @(posedge clk); #2;
        if (ack[d] || err[d]) begin
          lat = cyc_n - n + 1; od = rdat[d]; oe = err[d];
        end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      if (lat < 0) begin
        errors++;
        $display("FAIL timeout dut%0d adr=%h no response within 20 cycles", d, a);
      end
    end else begin
      @(posedge clk); #2;
      @(posedge clk); #2;
      cyc[d] = 1'b0; stb[d] = 1'b0;
      if (mode == 2) rst[d] = 1'b1;
      @(posedge clk);
      if (mode == 2) last_dat[d] = 32'd0;
      #2 rst[d] = 1'b0;
    end
  endtask

  // Strobe held continuously: back-to-back reads every WAIT_STATES+2 cycles.
  task automatic stream(input int d, input logic [31:0] a, input int count, output int acks);
    int   ws, n, idx;
    rsp_t r;
    ws  = (d == 0) ? 0 : 3;
    idx = int'(((a - BASE) / 4) % DEPTH);
    acks = 0;
    @(posedge clk); #2;
    cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = 1'b0; sel[d] = 4'hF; adr[d] = a;
    n = cyc_n + 1;
    for (int i = 0; i < count; i++) begin
      r.cyc = n + ws + i * (ws + 2); r.err = 1'b0; r.dat = mm[d][idx];
      push(d, r);
    end
    repeat ((count - 1) * (ws + 2) + ws + 1) begin
      @(posedge clk); #2;
      if (ack[d]) acks++;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] od;
    bit          oe;
    int          lat;
    int          acks;
    for (int d = 0; d < 2; d++) begin
      sel[d] = '0; adr[d] = '0; wd[d] = '0; last_dat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 2'b00;
    chk_en = 1'b1;

    // zero wait states
    xfer(0, 1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 0, od, oe, lat);
    chk("w0_lat", 32'(lat), 32'd1);
    chk("w0_wr_dat", od, 32'd0);
    xfer(0, 0, 4'hF, BASE + 32'h10, 32'h0, 0, od, oe, lat);
    chk("w0_rd_beef", od, 32'hDEAD_BEEF);
    chk("w0_rd_lat", 32'(lat), 32'd1);
    xfer(0, 1, 4'hF, BASE + 32'h14, 32'hAAAA_AAAA, 0, od, oe, lat);
    xfer(0, 1, 4'b0101, BASE + 32'h14, 32'h1122_3344, 0, od, oe, lat);
    xfer(0, 0, 4'hF, BASE + 32'h14, 32'h0, 0, od, oe, lat);
    chk("w0_partial", od, 32'hAA22_AA44);
    xfer(0, 1, 4'b0000, BASE + 32'h14, 32'hFFFF_FFFF, 0, od, oe, lat);
    xfer(0, 0, 4'hF, BASE + 32'h14, 32'h0, 0, od, oe, lat);
    chk("w0_sel0_write", od, 32'hAA22_AA44);
    xfer(0, 0, 4'b0000, BASE + 32'h10, 32'h0, 0, od, oe, lat);
    chk("w0_rd_sel0", od, 32'hDEAD_BEEF);
    stream(0, BASE + 32'h10, 3, acks);
    chk("w0_stream_acks", 32'(acks), 32'd3);

    // boundary: one word past the top of the window
    xfer(0, 1, 4'hF, BASE, 32'h1234_5678, 0, od, oe, lat);
    xfer(0, 1, 4'hF, BASE + DEPTH * 4, 32'hCAFE_F00D, 0, od, oe, lat);
`ifdef ZAP_WB_RESPONDER_ERR_EN
    chk("w0_oor_err", {31'd0, oe}, 32'd1);
    xfer(0, 0, 4'hF, BASE, 32'h0, 0, od, oe, lat);
    chk("w0_word0_kept", od, 32'h1234_5678);
`else
    chk("w0_oor_ack", {31'd0, oe}, 32'd0);
    xfer(0, 0, 4'hF, BASE, 32'h0, 0, od, oe, lat);
    chk("w0_word0_alias", od, 32'hCAFE_F00D);
`endif

    // three wait states
    xfer(1, 1, 4'hF, BASE + 32'h20, 32'h5566_7788, 0, od, oe, lat);
    chk("w3_wr_lat", 32'(lat), 32'd4);
    xfer(1, 0, 4'hF, BASE + 32'h20, 32'h0, 0, od, oe, lat);
    chk("w3_rd", od, 32'h5566_7788);
    chk("w3_rd_lat", 32'(lat), 32'd4);
    xfer(1, 1, 4'hF, BASE + 32'h20, 32'hBADB_AD00, 1, od, oe, lat);
    repeat (4) @(posedge clk);
    xfer(1, 0, 4'hF, BASE + 32'h20, 32'h0, 0, od, oe, lat);
    chk("w3_abort_kept", od, 32'h5566_7788);
    xfer(1, 1, 4'hF, BASE + 32'h20, 32'h0BAD_F00D, 2, od, oe, lat);
    repeat (4) @(posedge clk);
    xfer(1, 0, 4'hF, BASE + 32'h20, 32'h0, 0, od, oe, lat);
    chk("w3_reset_kept", od, 32'h5566_7788);
    chk("w3_post_reset_lat", 32'(lat), 32'd4);
    stream(1, BASE + 32'h20, 2, acks);
    chk("w3_stream_acks", 32'(acks), 32'd2);
    xfer(1, 0, 4'hF, BASE + DEPTH * 4 + 32'h20, 32'h0, 0, od, oe, lat);
`ifdef ZAP_WB_RESPONDER_ERR_EN
    chk("w3_oor_err", {31'd0, oe}, 32'd1);
    chk("w3_oor_dat", od, 32'd0);
`else
    chk("w3_oor_alias", od, 32'h5566_7788);
`endif

    repeat (6) @(posedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL pending_responses actual=%0d expected=0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
